// File: rtl/oled_pkg.sv
// oled_pkg: constants and types shared by the OLED serial-link blocks.
//   - command bytes understood by the panel (column window, row window, pixel write)
//   - decoder state enumeration used by oled_spi_receiver
//   - default RGB565 colours shared with the transmitter side
package oled_pkg;

    localparam logic [7:0] SetX     = 8'h15;
    localparam logic [7:0] SetY     = 8'h75;
    localparam logic [7:0] SetPixel = 8'h5C;

    localparam logic [15:0] ColorBlack = 16'h0000;
    localparam logic [15:0] ColorWhite = 16'hFFFF;
    localparam logic [15:0] ColorRed   = 16'hF800;
    localparam logic [15:0] ColorGreen = 16'h07E0;
    localparam logic [15:0] ColorBlue  = 16'h001F;

    typedef enum logic [2:0] {
        StIdle,
        StColStart,
        StColEnd,
        StRowStart,
        StRowEnd,
        StPixelHi,
        StPixelLo
    } dec_state_e;

endpackage

// File: rtl/oled_spi_deserializer.sv
// oled_spi_deserializer: samples the 4-wire OLED bus in the HCLK domain and
// assembles MSB-first bytes.
//   HCLK, HRESET        clock, asynchronous active-high reset
//   nCS, DnC, SDIN, SCLK raw serial bus inputs
//   byte_valid          one-cycle strobe when the 8th bit has been shifted in
//   byte_data           assembled byte
//   byte_dnc            DnC as sampled together with the 8th bit
module oled_spi_deserializer
    import oled_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       nCS,
    input  logic       DnC,
    input  logic       SDIN,
    input  logic       SCLK,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dnc
);

    logic       s_ncs;
    logic       s_dnc;
    logic       s_sdin;
    logic       s_sclk;
    logic       s_sclk_d;
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       bit_event;

    // Rising SCLK seen one cycle after sampling, only while selected.
    assign bit_event = s_sclk & ~s_sclk_d & ~s_ncs;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s_ncs      <= 1'b1;
            s_dnc      <= 1'b0;
            s_sdin     <= 1'b0;
            s_sclk     <= 1'b0;
            s_sclk_d   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dnc   <= 1'b0;
        end else begin
            s_ncs      <= nCS;
            s_dnc      <= DnC;
            s_sdin     <= SDIN;
            s_sclk     <= SCLK;
            s_sclk_d   <= s_sclk;
            byte_valid <= 1'b0;
            if (s_ncs) begin
                // Deselect drops any partial byte silently.
                bit_cnt <= '0;
            end else if (bit_event) begin
                shreg   <= {shreg[5:0], s_sdin};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg, s_sdin};
                    byte_dnc   <= s_dnc;
                end
            end
        end
    end

endmodule

// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: receive side of the OLED serial link. Deserialises the
// bus, decodes column/row window and pixel-write commands, and emits one
// pixel strobe per 16-bit colour with the current cursor position.
//   HCLK, HRESET                  clock, asynchronous active-high reset
//   nCS, DnC, SDIN, SCLK          serial bus inputs
//   byte_valid/byte_data/byte_dnc raw byte strobe and contents
//   pix_valid/pix_x/pix_y/pix_data pixel write strobe, position, colour
//   err_count                     saturating count of protocol errors
module oled_spi_receiver
    import oled_pkg::*;
#(
    parameter int CoordWidth = 7,
    parameter int ErrWidth   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  nCS,
    input  logic                  DnC,
    input  logic                  SDIN,
    input  logic                  SCLK,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  byte_dnc,
    output logic                  pix_valid,
    output logic [CoordWidth-1:0] pix_x,
    output logic [CoordWidth-1:0] pix_y,
    output logic [15:0]           pix_data,
    output logic [ErrWidth-1:0]   err_count
);

    dec_state_e state, state_n;

    logic [CoordWidth-1:0] col_start, col_end, row_start, row_end;
    logic [CoordWidth-1:0] cur_x, cur_y;
    logic [7:0]            hi_byte;

    logic err_inc, load_cursor, set_cs, set_ce, set_rs, set_re, latch_hi, emit_pix;

    oled_spi_deserializer u_deser (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .nCS        (nCS),
        .DnC        (DnC),
        .SDIN       (SDIN),
        .SCLK       (SCLK),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dnc   (byte_dnc)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= StIdle;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        err_inc     = 1'b0;
        load_cursor = 1'b0;
        set_cs      = 1'b0;
        set_ce      = 1'b0;
        set_rs      = 1'b0;
        set_re      = 1'b0;
        latch_hi    = 1'b0;
        emit_pix    = 1'b0;
        if (byte_valid) begin
            if (!byte_dnc) begin
                // Commands are honoured from any state and restart decoding.
                case (byte_data)
                    SetX:     state_n = StColStart;
                    SetY:     state_n = StRowStart;
                    SetPixel: begin
                        state_n     = StPixelHi;
                        load_cursor = 1'b1;
                    end
                    default: begin
                        state_n = StIdle;
                        err_inc = 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    StColStart: begin set_cs = 1'b1; state_n = StColEnd;  end
                    StColEnd:   begin set_ce = 1'b1; state_n = StIdle;    end
                    StRowStart: begin set_rs = 1'b1; state_n = StRowEnd;  end
                    StRowEnd:   begin set_re = 1'b1; state_n = StIdle;    end
                    StPixelHi:  begin latch_hi = 1'b1; state_n = StPixelLo; end
                    StPixelLo:  begin emit_pix = 1'b1; state_n = StPixelHi; end
                    default:    begin err_inc = 1'b1; state_n = StIdle;   end
                endcase
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            col_start <= '0;
            col_end   <= '1;
            row_start <= '0;
            row_end   <= '1;
            cur_x     <= '0;
            cur_y     <= '0;
            hi_byte   <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
            err_count <= '0;
        end else begin
            pix_valid <= emit_pix;
            if (set_cs) col_start <= byte_data[CoordWidth-1:0];
            if (set_ce) col_end   <= byte_data[CoordWidth-1:0];
            if (set_rs) row_start <= byte_data[CoordWidth-1:0];
            if (set_re) row_end   <= byte_data[CoordWidth-1:0];
            if (latch_hi) hi_byte <= byte_data;
            if (load_cursor) begin
                cur_x <= col_start;
                cur_y <= row_start;
            end
            if (emit_pix) begin
                pix_x    <= cur_x;
                pix_y    <= cur_y;
                pix_data <= {hi_byte, byte_data};
                // Raster advance; start>end windows wrap through the top of
                // the coordinate range naturally via modulo increment.
                if (cur_x == col_end) begin
                    cur_x <= col_start;
                    cur_y <= (cur_y == row_end) ? row_start : cur_y + 1'b1;
                end else begin
                    cur_x <= cur_x + 1'b1;
                end
            end
            if (err_inc && (err_count != '1)) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_oled_spi_receiver.sv
module tb_oled_spi_receiver;

    localparam int CW = 7;
    localparam int EW = 8;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          nCS, DnC, SDIN, SCLK;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_dnc;
    logic          pix_valid;
    logic [CW-1:0] pix_x, pix_y;
    logic [15:0]   pix_data;
    logic [EW-1:0] err_count;

    oled_spi_receiver #(.CoordWidth(CW), .ErrWidth(EW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .nCS        (nCS),
        .DnC        (DnC),
        .SDIN       (SDIN),
        .SCLK       (SCLK),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dnc   (byte_dnc),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data),
        .err_count  (err_count)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-level protocol semantics.
    localparam int M_IDLE = 0, M_CS = 1, M_CE = 2, M_RS = 3, M_RE = 4, M_HI = 5, M_LO = 6;
    int mmode, mcs, mce, mrs, mre, mx, my, merr, mhi;
    logic [8:0]  exp_byte[$];
    logic [29:0] exp_pix[$];

    function automatic int inc_mod(input int v);
        return (v + 1) % (1 << CW);
    endfunction

    task automatic model_reset();
        mmode = M_IDLE; mcs = 0; mce = (1 << CW) - 1; mrs = 0; mre = (1 << CW) - 1;
        mx = 0; my = 0; merr = 0; mhi = 0;
        exp_byte.delete();
        exp_pix.delete();
    endtask

    task automatic model_err();
        if (merr < (1 << EW) - 1) merr++;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic d);
        int v;
        v = int'(b) % (1 << CW);
        exp_byte.push_back({d, b});
        if (!d) begin
            if (b == 8'h15)      mmode = M_CS;
            else if (b == 8'h75) mmode = M_RS;
            else if (b == 8'h5C) begin mmode = M_HI; mx = mcs; my = mrs; end
            else begin mmode = M_IDLE; model_err(); end
        end else begin
            case (mmode)
                M_CS: begin mcs = v; mmode = M_CE; end
                M_CE: begin mce = v; mmode = M_IDLE; end
                M_RS: begin mrs = v; mmode = M_RE; end
                M_RE: begin mre = v; mmode = M_IDLE; end
                M_HI: begin mhi = int'(b); mmode = M_LO; end
                M_LO: begin
                    exp_pix.push_back({mx[CW-1:0], my[CW-1:0], mhi[7:0], b});
                    if (mx == mce) begin
                        mx = mcs;
                        my = (my == mre) ? mrs : inc_mod(my);
                    end else begin
                        mx = inc_mod(mx);
                    end
                    mmode = M_HI;
                end
                default: model_err();
            endcase
        end
    endtask

    // Bus driver
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_bits(input logic [7:0] b, input logic d, input int nbits, input bit rnd);
        logic [7:0] sr;
        sr = b;
        for (int i = 0; i < nbits; i++) begin
            nCS = 1'b0; DnC = d; SDIN = sr[7]; SCLK = 1'b0;
            repeat (rnd ? $urandom_range(1, 2) : 1) step();
            SCLK = 1'b1;
            repeat (rnd ? $urandom_range(1, 2) : 1) step();
            sr = {sr[6:0], 1'b0};
        end
        SCLK = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        model_byte(b, d);
        send_bits(b, d, 8, 1'b1);
    endtask

    task automatic send_abort(input int nbits);
        send_bits(8'($urandom), 1'($urandom), nbits, 1'b1);
        nCS = 1'b1;
        idle(3);
    endtask

    task automatic check_err(input string tag);
        idle(5);
        check(tag, 32'(err_count), 32'(merr));
    endtask

    task automatic check_reset_outputs();
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_byte_data", 32'(byte_data), 0);
        check("rst_byte_dnc", 32'(byte_dnc), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_pix_xy", 32'({pix_x, pix_y}), 0);
        check("rst_pix_data", 32'(pix_data), 0);
        check("rst_err", 32'(err_count), 0);
    endtask

    // Output monitor: every strobe must match the next model expectation.
    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (byte_valid) begin
                if (exp_byte.size() == 0) check("byte_unexpected", 32'(byte_valid), 0);
                else begin
                    logic [8:0] e;
                    e = exp_byte.pop_front();
                    check("byte_data", 32'(byte_data), 32'(e[7:0]));
                    check("byte_dnc", 32'(byte_dnc), 32'(e[8]));
                end
            end
            if (pix_valid) begin
                if (exp_pix.size() == 0) check("pix_unexpected", 32'(pix_valid), 0);
                else begin
                    logic [29:0] p;
                    p = exp_pix.pop_front();
                    check("pix_x", 32'(pix_x), 32'(p[29:23]));
                    check("pix_y", 32'(pix_y), 32'(p[22:16]));
                    check("pix_data", 32'(pix_data), 32'(p[15:0]));
                end
            end
        end
    end

    initial begin
        logic [15:0] c;
        nCS = 1'b1; DnC = 1'b0; SDIN = 1'b0; SCLK = 1'b0;
        HRESET = 1'b1;
        model_reset();
        idle(3);
        check_reset_outputs();
        HRESET = 1'b0;
        idle(2);

        // Single data byte in Idle
        send_byte(8'hA5, 1'b1);
        check_err("err_data_idle");

        // Window 16..17 x 32..33, four pixels
        send_byte(8'h15, 1'b0); send_byte(8'h10, 1'b1); send_byte(8'h11, 1'b1);
        send_byte(8'h75, 1'b0); send_byte(8'h20, 1'b1); send_byte(8'h21, 1'b1);
        send_byte(8'h5C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            c = 16'($urandom);
            send_byte(c[15:8], 1'b1); send_byte(c[7:0], 1'b1);
        end
        check_err("err_window");

        // Column window wrapping 127 -> 0 -> 1, single row
        send_byte(8'h15, 1'b0); send_byte(8'h7F, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h75, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h5C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            c = 16'($urandom);
            send_byte(c[15:8], 1'b1); send_byte(c[7:0], 1'b1);
        end

        // Aborted partial byte, then a full byte
        send_abort(5);
        send_byte(8'h3C, 1'b1);
        check_err("err_abort");

        // Unknown command, data in Idle, then partial pixel cut by a command
        send_byte(8'hAF, 1'b0);
        check_err("err_bad_cmd");
        send_byte(8'h00, 1'b1);
        check_err("err_after_bad_cmd");
        send_byte(8'h5C, 1'b0); send_byte(8'hFF, 1'b1); send_byte(8'h15, 1'b0);
        check_err("err_partial_pixel");

        // Reset in the middle of a byte
        send_bits(8'hC3, 1'b1, 4, 1'b0);
        HRESET = 1'b1;
        model_reset();
        nCS = 1'b1;
        idle(2);
        check_reset_outputs();
        HRESET = 1'b0;
        idle(2);
        send_byte(8'h75, 1'b0); send_byte(8'h05, 1'b1); send_byte(8'h06, 1'b1);
        send_byte(8'h5C, 1'b0); send_byte(8'h3C, 1'b1); send_byte(8'h06, 1'b1);
        check_err("err_post_reset");

        // Randomised traffic
        for (int g = 0; g < 120; g++) begin
            int kind;
            kind = $urandom_range(0, 9);
            case (kind)
                0: begin send_byte(8'h15, 1'b0); send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1); end
                1: begin send_byte(8'h75, 1'b0); send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1); end
                7: send_byte(8'($urandom), 1'b0);
                8: send_byte(8'($urandom), 1'b1);
                9: send_abort($urandom_range(1, 7));
                default: begin
                    int n;
                    n = $urandom_range(1, 6);
                    send_byte(8'h5C, 1'b0);
                    for (int i = 0; i < n; i++) begin
                        send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1);
                    end
                    if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b1);
                end
            endcase
        end
        check_err("err_random");

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            model_byte(8'hAF, 1'b0);
            send_bits(8'hAF, 1'b0, 8, 1'b0);
        end
        check_err("err_saturate");

        idle(5);
        check("bytes_outstanding", 32'(exp_byte.size()), 0);
        check("pix_outstanding", 32'(exp_pix.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
